rfphoenix_dcache_fill_seq: RTL
==============================

Name: rfphoenix_dcache_fill_seq

Overview:
Data-cache miss/fill sequencer for the rfPhoenix dcache. It accepts a line-fill request from the memory stage and selects a victim way. It then runs a BEATS-long bus read burst, strobing the way write enable for each returned beat, and finishes with a tag/valid write and a single-cycle done pulse. It owns the replacement LFSR and the write-way select that the per-way storage consumes.

Parameters:
WAYS, 4, number of cache ways (power of two, 2..8)
BEATS, 4, bus beats per cache line (power of two, 2..16)
AWID, 32, address width
LOBIT, 6, log2 of line size in bytes; line address = adr[AWID-1:LOBIT]

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_i  in  1  fill request; sampled only in IDLE
req_adr_i  in  AWID  miss address
req_rdy_o  out  1  high in IDLE only
valid_i  in  WAYS  valid bits of the indexed set, stable from VICTIM onward
cyc_o  out  1  bus cycle active
stb_o  out  1  bus strobe
adr_o  out  AWID  beat address
ack_i  in  1  bus beat acknowledge
err_i  in  1  bus error
wr_dc_o  out  1  per-beat data write strobe to ways
wr_beat_o  out  $clog2(BEATS)  beat index for wr_dc_o
wway_o  out  $clog2(WAYS)  way being filled
tag_wr_o  out  1  tag+valid write strobe (one cycle)
done_o  out  1  fill complete pulse
err_o  out  1  fill aborted pulse
lfsr_o  out  8  current LFSR state (debug)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all strobes 0, cyc_o=stb_o=0, adr_o=0, wway_o=0, wr_beat_o=0, lfsr=8'h01, state=IDLE. A reset asserted mid-burst drops cyc_o/stb_o the next edge. No tag_wr_o is issued for that burst.
- LFSR: 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1. It advances every cycle when not in reset. The all-zero state is unreachable.
- States: IDLE, VICTIM, BURST, TAGWR, DONE, ERR.
- IDLE: req_rdy_o=1. On req_i, latch line address and go to VICTIM.
- VICTIM (1 cycle): wway_o <= lfsr[$clog2(WAYS)-1:0] (see optional feature). Then go to BURST with beat counter=0, cyc_o=stb_o=1, and adr_o={line,beat,zero offset}.
- BURST: each cycle with ack_i=1:
  - wr_dc_o=1 for exactly that cycle (registered, so it is visible the cycle after ack).
  - wr_beat_o=counter.
  - Counter increments and adr_o advances one beat.
  - On the ack of beat BEATS-1, drop cyc_o/stb_o and go to TAGWR.
  - ack_i low: hold all bus outputs.
- TAGWR: tag_wr_o=1 for one cycle with wway_o held. Then go to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- wway_o is stable from VICTIM through DONE.
- err_i during BURST, including a cycle where ack_i is also high: err wins and that beat is not written. Drop cyc_o/stb_o, go to ERR, pulse err_o one cycle, return to IDLE. No tag_wr_o is issued.
- ack_i/err_i outside BURST: ignored.
- Counter wrap: the counter width is exactly $clog2(BEATS). The last beat is detected by counter==BEATS-1, not by overflow.
- req_i held high through DONE: not re-accepted until IDLE. Minimum back-to-back fill spacing = BEATS+4 cycles with zero-wait ack.

Optional Feature:
DCACHE_INVALID_FIRST_EN
- Defined: in VICTIM, if any valid_i bit is 0, wway_o = lowest-index invalid way, and the LFSR is used only when the set is full.
- Undefined: valid_i is ignored (may be left unconnected) and the victim is always taken from the LFSR.

Decomposition:
- Shared package (rfPhoenixPkg): state enum dcfill_state_t, DC_WAYS/DC_BEATS/DC_LOBIT defaults, and the LFSR tap constant.
- One natural sub-module: rfphoenix_lfsr8 (free-running 8-bit Galois LFSR, synchronous reset to 8'h01), reused by the icache later.

Test Plan:
- Reset, then 10 idle cycles -> lfsr_o sequence 01,B8,5C,2E,17,B3,E1,C8,64,32 (Galois shift right, XOR 8'hB8 when LSB=1); all strobes 0; req_rdy_o=1.
- req_i with req_adr_i=32'h0000_1234 and zero-wait ack -> four beats:
  - adr_o sequence 1200,1210,1220,1230 (16-byte beats, LOBIT=6).
  - wr_dc_o pulses with wr_beat_o 0..3.
  - Then tag_wr_o, then done_o, at 8 cycles from accept.
- ack_i stalled 3 cycles before beat 2 -> bus outputs and adr_o=…1220 held; wr_dc_o stays low during the stall; exactly 4 wr_dc_o pulses in total.
- err_i with ack_i on beat 1 -> only beat 0 written; err_o pulse; no tag_wr_o; next req_i accepted.
- With DCACHE_INVALID_FIRST_EN defined and valid_i=4'b1011 -> wway_o=2. With valid_i=4'b1111 -> wway_o = LFSR low bits at VICTIM.
- rst asserted during beat 2 -> next edge cyc_o=0 and state IDLE; no tag_wr_o/done_o; a new fill completes normally.

Source files
------------

// File: rtl/rfphoenix_dcache_fill_seq_pkg.sv
// Shared definitions for the rfPhoenix dcache fill sequencer:
// fill FSM state enum, default geometry, and the replacement LFSR taps/step.
package rfphoenix_dcache_fill_seq_pkg;

    localparam int DC_WAYS  = 4;
    localparam int DC_BEATS = 4;
    localparam int DC_LOBIT = 6;

    // Galois taps for x^8+x^6+x^5+x^4+1 in shift-right form
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VICTIM,
        ST_BURST,
        ST_TAGWR,
        ST_DONE,
        ST_ERR
    } dcfill_state_t;

    function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/rfphoenix_dcache_fill_seq_lfsr8.sv
// Free-running 8-bit Galois LFSR used for pseudo-random way replacement.
// Ports: clk, rst (sync, active-high, reseeds to 8'h01), lfsr_o (state).
module rfphoenix_lfsr8
    import rfphoenix_dcache_fill_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] lfsr_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // A nonzero seed never reaches zero, so no lockup recovery is needed.
    always_comb begin
        lfsr_d = lfsr8_next(lfsr_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 8'h01;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/rfphoenix_dcache_fill_seq.sv
// Dcache line-fill sequencer: victim select, BEATS-long read burst with a
// registered per-beat way write strobe, tag/valid write, done/err pulses.
// Ports: req_i/req_adr_i/req_rdy_o (fill request), valid_i (set valid bits),
// cyc_o/stb_o/adr_o/ack_i/err_i (bus), wr_dc_o/wr_beat_o/wway_o/tag_wr_o
// (way storage), done_o/err_o (status), lfsr_o (debug).
// Build option DCACHE_INVALID_FIRST_EN: fill the lowest invalid way first.
module rfphoenix_dcache_fill_seq
    import rfphoenix_dcache_fill_seq_pkg::*;
#(
    parameter int WAYS  = DC_WAYS,
    parameter int BEATS = DC_BEATS,
    parameter int AWID  = 32,
    parameter int LOBIT = DC_LOBIT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_i,
    input  logic [AWID-1:0]          req_adr_i,
    output logic                     req_rdy_o,
    input  logic [WAYS-1:0]          valid_i,
    output logic                     cyc_o,
    output logic                     stb_o,
    output logic [AWID-1:0]          adr_o,
    input  logic                     ack_i,
    input  logic                     err_i,
    output logic                     wr_dc_o,
    output logic [$clog2(BEATS)-1:0] wr_beat_o,
    output logic [$clog2(WAYS)-1:0]  wway_o,
    output logic                     tag_wr_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [7:0]               lfsr_o
);

    localparam int BW = $clog2(BEATS);
    localparam int WW = $clog2(WAYS);
    localparam int LW = AWID - LOBIT;
    localparam int OW = LOBIT - BW;

    dcfill_state_t state_q, state_d;
    logic [LW-1:0] line_q, line_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic [AWID-1:0] adr_q, adr_d;
    logic cyc_q, cyc_d;
    logic wr_dc_q, wr_dc_d;
    logic [BW-1:0] wr_beat_q, wr_beat_d;
    logic [WW-1:0] wway_q, wway_d;
    logic [WW-1:0] victim;
    logic [7:0] lfsr;
    logic unused_bits;

    rfphoenix_lfsr8 u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .lfsr_o (lfsr)
    );

`ifdef DCACHE_INVALID_FIRST_EN
    // Scan high to low so the lowest-index invalid way wins.
    always_comb begin
        victim = lfsr[WW-1:0];
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid_i[i]) victim = i[WW-1:0];
        end
    end
    assign unused_bits = ^req_adr_i[LOBIT-1:0];
`else
    always_comb begin
        victim = lfsr[WW-1:0];
    end
    assign unused_bits = ^{req_adr_i[LOBIT-1:0], valid_i};
`endif

    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        cnt_d     = cnt_q;
        adr_d     = adr_q;
        cyc_d     = cyc_q;
        wr_dc_d   = 1'b0;
        wr_beat_d = wr_beat_q;
        wway_d    = wway_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    line_d  = req_adr_i[AWID-1:LOBIT];
                    state_d = ST_VICTIM;
                end
            end
            ST_VICTIM: begin
                wway_d  = victim;
                cnt_d   = '0;
                cyc_d   = 1'b1;
                adr_d   = {line_q, {BW{1'b0}}, {OW{1'b0}}};
                state_d = ST_BURST;
            end
            ST_BURST: begin
                // A bus error overrides a coincident ack: that beat is dropped.
                if (err_i) begin
                    cyc_d   = 1'b0;
                    state_d = ST_ERR;
                end else if (ack_i) begin
                    wr_dc_d   = 1'b1;
                    wr_beat_d = cnt_q;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == BW'(BEATS - 1)) begin
                        cyc_d   = 1'b0;
                        state_d = ST_TAGWR;
                    end else begin
                        adr_d = {line_q, cnt_q + 1'b1, {OW{1'b0}}};
                    end
                end
            end
            ST_TAGWR: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            line_q    <= '0;
            cnt_q     <= '0;
            adr_q     <= '0;
            cyc_q     <= 1'b0;
            wr_dc_q   <= 1'b0;
            wr_beat_q <= '0;
            wway_q    <= '0;
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            cnt_q     <= cnt_d;
            adr_q     <= adr_d;
            cyc_q     <= cyc_d;
            wr_dc_q   <= wr_dc_d;
            wr_beat_q <= wr_beat_d;
            wway_q    <= wway_d;
        end
    end

    assign req_rdy_o = (state_q == ST_IDLE);
    assign cyc_o     = cyc_q;
    assign stb_o     = cyc_q;
    assign adr_o     = adr_q;
    assign wr_dc_o   = wr_dc_q;
    assign wr_beat_o = wr_beat_q;
    assign wway_o    = wway_q;
    assign tag_wr_o  = (state_q == ST_TAGWR);
    assign done_o    = (state_q == ST_DONE);
    assign err_o     = (state_q == ST_ERR);
    assign lfsr_o    = lfsr;

endmodule
